// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop walks two
// WIDTH-bit operands LSB-first, one bit per clock, behind a start/done handshake.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic busy_nxt, done_nxt;
  logic accept, last, bit_s, bit_c;
  logic carry;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;

  // State register; busy/done are registered copies of the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = start ? S_RUN : S_IDLE;
      S_RUN:   state_nxt = last ? S_DONE : S_RUN;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode and the single full-adder cell
  always_comb begin
    busy_nxt = (state_nxt == S_RUN);
    done_nxt = (state_nxt == S_DONE);
    accept   = start && ((state == S_IDLE) || (state == S_DONE));
    last     = (cnt == LAST);
    bit_s    = a_sr[0] ^ b_sr[0] ^ carry;
    bit_c    = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    // New bit enters at the MSB so the result fills LSB-first.
    res_nxt  = (res_sr >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
  end

  // Datapath: operand shift registers, carry flop, bit counter, result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_nxt;
      carry  <= bit_c;
      if (last) begin
        sum  <= res_nxt;
        cout <= bit_c;
        ovf  <= carry ^ bit_c;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized checks of serial_adder at WIDTH = 8, 1 and 32.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] a_v, b_v;
  logic        sub_v, cin_v;
  logic        start8, start1, start32;

  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;
  logic        busy1, done1, cout1, ovf1;
  logic [0:0]  sum1;
  logic        busy32, done32, cout32, ovf32;
  logic [31:0] sum32;

  int n_tests = 0;
  int n_fail  = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub_v), .a(a_v[7:0]), .b(b_v[7:0]),
    .cin(cin_v), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub_v), .a(a_v[0:0]), .b(b_v[0:0]),
    .cin(cin_v), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .sub(sub_v), .a(a_v[31:0]), .b(b_v[31:0]),
    .cin(cin_v), .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .ovf(ovf32)
  );

  typedef struct {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Independent arithmetic reference: full-width add plus a (w-1)-bit add for the MSB carry-in.
  task automatic ref_model(input int w, input logic [63:0] av, input logic [63:0] bv,
                           input logic s, input logic ci,
                           output logic [63:0] rs, output logic rc, output logic ro);
    logic [63:0] mask, lowmask, bb;
    logic [64:0] full, low;
    logic c0;
    mask    = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    lowmask = (64'd1 << (w - 1)) - 64'd1;
    bb      = s ? (~bv & mask) : (bv & mask);
    c0      = s ? 1'b1 : ci;
    full    = {1'b0, av & mask} + {1'b0, bb} + 65'(c0);
    low     = {1'b0, av & lowmask} + {1'b0, bb & lowmask} + 65'(c0);
    rs      = full[63:0] & mask;
    rc      = full[w];
    ro      = low[w-1] ^ full[w];
  endtask

  // Launch one operation on instance id (0:W8, 1:W1, 2:W32) and wait for done.
  // lat counts edges from the start edge (=1) to the edge after which done is seen.
  task automatic run_op(input int id, input logic s, input logic [63:0] av, input logic [63:0] bv,
                        input logic ci, output logic [63:0] rs, output logic rc, output logic ro,
                        output int lat, output int nbusy);
    int w;
    logic d, bz;
    w = (id == 0) ? 8 : (id == 1) ? 1 : 32;
    lat = -1; nbusy = 0; rs = '0; rc = 1'b0; ro = 1'b0;
    @(negedge clk);
    sub_v = s; a_v = av; b_v = bv; cin_v = ci;
    case (id)
      0: start8 = 1'b1;
      1: start1 = 1'b1;
      default: start32 = 1'b1;
    endcase
    for (int k = 1; k <= w + 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        start8 = 1'b0; start1 = 1'b0; start32 = 1'b0;
      end
      case (id)
        0: begin d = done8; bz = busy8; rs = 64'(sum8); rc = cout8; ro = ovf8; end
        1: begin d = done1; bz = busy1; rs = 64'(sum1); rc = cout1; ro = ovf1; end
        default: begin d = done32; bz = busy32; rs = 64'(sum32); rc = cout32; ro = ovf32; end
      endcase
      if (bz) nbusy++;
      if (d) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    logic [63:0] rs, es, av, bv;
    logic rc, ro, ec, eo, s, ci;
    int lat, nbusy, first, second, npulse;
    logic [7:0] s1, s2;
    logic c1, o1;

    vecs[0] = '{1'b0, 8'h3C, 8'h45, 1'b0, 8'h81, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 8'h7F, 8'h01, 1'b1, 8'h81, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 8'h05, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0};

    rst = 1'b1; a_v = '0; b_v = '0; sub_v = 1'b0; cin_v = 1'b0;
    start8 = 1'b0; start1 = 1'b0; start32 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("idle_w8", {busy8, done8, sum8, cout8, ovf8}, '0);
    end
    check("idle_w1", {busy1, done1, sum1, cout1, ovf1}, '0);
    check("idle_w32", {busy32, done32, sum32, cout32, ovf32}, '0);

    // Directed vector table on WIDTH=8
    for (int i = 0; i < 9; i++) begin
      run_op(0, vecs[i].sub, 64'(vecs[i].a), 64'(vecs[i].b), vecs[i].cin, rs, rc, ro, lat, nbusy);
      check($sformatf("vec%0d_sum", i), rs, 64'(vecs[i].sum));
      check($sformatf("vec%0d_cout", i), 64'(rc), 64'(vecs[i].cout));
      check($sformatf("vec%0d_ovf", i), 64'(ro), 64'(vecs[i].ovf));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd9);
      check($sformatf("vec%0d_busy_cycles", i), 64'(nbusy), 64'd8);
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_pulse", i), 64'(done8), 64'd0);
      check($sformatf("vec%0d_hold_sum", i), 64'(sum8), 64'(vecs[i].sum));
    end

    // Start held high with operands churning during RUN; second op taken at the DONE edge
    first = -1; second = -1; s1 = '0; s2 = '0; c1 = 1'b0; o1 = 1'b0;
    @(negedge clk);
    a_v = 64'h3C; b_v = 64'h45; sub_v = 1'b0; cin_v = 1'b0; start8 = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (first > 0 && k == first + 1) begin
        check("hs_accept_busy", 64'(busy8), 64'd1);
        check("hs_done_pulse", 64'(done8), 64'd0);
        start8 = 1'b0;
      end else if (done8) begin
        if (first < 0) begin
          first = k; s1 = sum8; c1 = cout8; o1 = ovf8;
          a_v = 64'h10; b_v = 64'h20; sub_v = 1'b1; cin_v = 1'b0;
        end else begin
          second = k; s2 = sum8;
          break;
        end
      end else if (first < 0) begin
        a_v = 64'(k * 37); b_v = ~a_v; sub_v = k[0]; cin_v = k[1];
      end
    end
    start8 = 1'b0;
    check("hs_first_latency", 64'(first), 64'd9);
    check("hs_first_sum", 64'(s1), 64'h81);
    check("hs_first_flags", 64'({c1, o1}), 64'b01);
    check("hs_spacing", 64'(second - first), 64'd9);
    check("hs_second_sum", 64'(s2), 64'hF0);

    // Reset in the middle of an operation
    @(negedge clk);
    a_v = 64'h3C; b_v = 64'h45; sub_v = 1'b0; cin_v = 1'b0; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_outputs", {busy8, done8, sum8, cout8, ovf8}, '0);
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8 || busy8) npulse++;
    end
    check("rst_mid_no_done", 64'(npulse), 64'd0);
    run_op(0, 1'b0, 64'h3C, 64'h45, 1'b0, rs, rc, ro, lat, nbusy);
    check("rst_after_sum", rs, 64'h81);
    check("rst_after_latency", 64'(lat), 64'd9);

    // WIDTH=1 corner
    run_op(1, 1'b0, 64'h1, 64'h1, 1'b0, rs, rc, ro, lat, nbusy);
    check("w1_corner", {rs[0], rc, ro}, 64'b011);
    check("w1_corner_latency", 64'(lat), 64'd2);

    // Random sweeps for WIDTH=1 and WIDTH=32
    for (int id = 1; id <= 2; id++) begin
      int w;
      w = (id == 1) ? 1 : 32;
      for (int i = 0; i < 1000; i++) begin
        s  = 1'($urandom_range(0, 1));
        ci = 1'($urandom_range(0, 1));
        av = {$urandom(), $urandom()};
        bv = {$urandom(), $urandom()};
        ref_model(w, av, bv, s, ci, es, ec, eo);
        run_op(id, s, av, bv, ci, rs, rc, ro, lat, nbusy);
        check($sformatf("w%0d_sum", w), rs, es);
        check($sformatf("w%0d_cout", w), 64'(rc), 64'(ec));
        check($sformatf("w%0d_ovf", w), 64'(ro), 64'(eo));
        check($sformatf("w%0d_latency", w), 64'(lat), 64'(w + 1));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder/subtractor. It is the sequential successor to the single-bit full adder.
- A single full-adder cell plus a carry flip-flop processes two WIDTH-bit operands LSB-first, one bit per clock.
- Operation uses a start/done handshake and produces sum, carry-out and signed-overflow flags.
- Used where area matters more than latency, e.g. in the small datapaths and ALU experiments of the codebase.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request a new operation; sampled only when busy=0
- sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1 with cin ignored
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in for add mode, captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; result outputs are valid from this cycle
- sum  output  WIDTH  result
- cout  output  1  carry out of the MSB; in sub mode 1 means no borrow
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; busy, done, sum, cout, ovf, internal shift registers, carry FF and bit counter all cleared to 0.
- rst has priority over every other input, including in mid-operation. An operation interrupted by reset is abandoned, and no done is produced for it.
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. On an edge with start=1 the block does the following, then goes to RUN:
  - captures a into A shift register
  - captures (sub ? ~b : b) into B shift register
  - loads carry FF with (sub ? 1 : cin)
  - sets counter=0
- RUN: busy=1. Each edge does the following:
  - s = A[0]^B[0]^c; shifts s into the MSB of the result shift register (LSB-first fill).
  - c <= majority(A[0],B[0],c); A and B shift right by one.
  - When counter=WIDTH-1, the carry into this bit is recorded for ovf; counter otherwise increments.
  - After processing bit WIDTH-1, goes to DONE.
- start and operand changes during RUN are ignored and have no effect on the running operation.
- DONE: lasts exactly one cycle. busy=0, done=1; sum, cout and ovf are updated and valid this cycle.
  - start=1 on the edge leaving DONE is accepted exactly as in IDLE, giving back-to-back operation with no gap; otherwise the block goes to IDLE.
- Latency: if start is accepted at edge T, busy=1 for cycles T..T+WIDTH-1, and done=1 in the cycle following edge T+WIDTH. Throughput is one result per WIDTH+1 cycles.
- sum, cout and ovf hold their values after done until the next done. They update only on entry to DONE, never during RUN.
- WIDTH=1: RUN lasts one cycle. ovf = carry-in XOR cout of that single bit.
- Arithmetic is modulo 2^WIDTH. No saturation.

Test Plan:
- Reset then idle (WIDTH=8), start=0 for 20 cycles -> busy=0, done=0, sum=0x00, cout=0, ovf=0 throughout.
- Add mode:
  - a=0x3C, b=0x45, cin=0 -> done exactly 9 cycles after the start edge; sum=0x81, cout=0, ovf=1.
  - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
  - a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1, ovf=0.
- Sub mode:
  - a=0x10, b=0x20 -> sum=0xF0, cout=0, ovf=0.
  - a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
  - Repeat with cin=1 -> identical results.
- Handshake:
  - start held high with changing a/b during RUN -> first result unaffected, and a second operation is accepted only on the DONE-cycle edge.
  - Back-to-back results appear 9 cycles apart, each with a one-cycle done pulse.
- Reset mid-operation: assert rst at bit 4 of a=0x3C+b=0x45 -> the next cycle shows busy=0, all outputs 0, and no done pulse. A new start afterwards gives the correct 0x81.
- Parameter sweep, WIDTH=1 and WIDTH=32, random operands in both modes (≥1000 ops each):
  - sum, cout and ovf match a reference model.
  - done arrives WIDTH+1 cycles after start.
  - For WIDTH=1, a=1, b=1, cin=0 -> sum=0, cout=1, ovf=1.
